// File: rtl/cpu_bus_x_pkg.sv
// Shared types and byte-lane helpers for the cpu_bus_x adapter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_e;

  // Replace one byte lane of a word; lane 0 is bits [7:0].
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/cpu_bus_x_if.sv
// Core-side and bus-side handshake signals of the cpu_bus_x adapter.
interface cpu_bus_x_if #(
  parameter int ADDR_W = 24
) ();
  logic              cpu_stb;
  logic              cpu_we;
  logic              cpu_ben;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_dout;
  logic [31:0]       cpu_din;
  logic              cpu_ack;
  logic              bus_stb;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [31:0]       bus_dout;
  logic [31:0]       bus_din;
  logic              bus_ack;

  // Adapter view.
  modport slave (
    input  cpu_stb, cpu_we, cpu_ben, cpu_addr, cpu_dout, bus_din, bus_ack,
    output cpu_din, cpu_ack, bus_stb, bus_we, bus_addr, bus_dout
  );

  // Environment view: core plus system bus.
  modport master (
    output cpu_stb, cpu_we, cpu_ben, cpu_addr, cpu_dout, bus_din, bus_ack,
    input  cpu_din, cpu_ack, bus_stb, bus_we, bus_addr, bus_dout
  );
endinterface

// File: rtl/cpu_bus_x_tmo.sv
// Bus-phase watchdog: expired_o marks the cycle whose increment would reach all-ones.
module cpu_bus_tmo #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam logic [TMO_W-1:0] LAST_Q = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] ONE_Q  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt_q;

  assign expired_o = enable_i && (cnt_q == LAST_Q);

  // Cycle counter of the current bus phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + ONE_Q;
    end else begin
      cnt_q <= cnt_q;
    end
  end
endmodule

// File: rtl/cpu_bus_x.sv
// cpu_bus_x: turns core byte/word accesses into word-only bus cycles (RMW for
// byte stores), aborts hung cycles, and flags stack-limit violations.
module cpu_bus_x
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int TMO_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  cpu_bus_x_if.slave  bif,
  input  logic        err_clr,
  input  logic [31:0] spx,
  input  logic [31:0] sp_limit,
  input  logic        stk_en,
  output logic        bus_err,
  output logic        stk_ovfl
);
  state_e            state_q;
  logic              cpu_ack_q, bus_stb_q, bus_we_q;
  logic [31:0]       cpu_din_q, bus_dout_q;
  logic [ADDR_W-3:0] bus_addr_q;
  logic              req_we_q, req_ben_q;
  logic [1:0]        req_lane_q;
  logic [7:0]        req_byte_q;
  logic              bus_err_q, stk_ovfl_q;
  logic              ack_s, tmo_clr_s, tmo_exp_s, tmo_evt_s, stk_low_s;

  assign ack_s     = bif.bus_ack && bus_stb_q;
  assign tmo_clr_s = !bus_stb_q || bif.bus_ack;
  // An ack in the expiry cycle wins: that phase completes normally.
  assign tmo_evt_s = tmo_exp_s && !bif.bus_ack;
  assign stk_low_s = stk_en && (spx < sp_limit);

  cpu_bus_tmo #(.TMO_W(TMO_W)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmo_clr_s),
    .enable_i  (bus_stb_q),
    .expired_o (tmo_exp_s)
  );

  // Access sequencer with registered core and bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cpu_ack_q  <= 1'b0;
      cpu_din_q  <= 32'h0000_0000;
      bus_stb_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_dout_q <= 32'h0000_0000;
      req_we_q   <= 1'b0;
      req_ben_q  <= 1'b0;
      req_lane_q <= 2'd0;
      req_byte_q <= 8'h00;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bif.cpu_stb) begin
            req_we_q   <= bif.cpu_we;
            req_ben_q  <= bif.cpu_ben;
            req_lane_q <= bif.cpu_addr[1:0];
            req_byte_q <= bif.cpu_dout[7:0];
            bus_addr_q <= bif.cpu_addr[ADDR_W-1:2];
            bus_stb_q  <= 1'b1;
            if (bif.cpu_we && !bif.cpu_ben) begin
              state_q    <= WR;
              bus_we_q   <= 1'b1;
              bus_dout_q <= bif.cpu_dout;
            end else begin
              state_q  <= RD;
              bus_we_q <= 1'b0;
            end
          end
        end
        RD: begin
          if (ack_s) begin
            // Only byte stores reach RD with req_we_q set.
            if (req_we_q) begin
              state_q    <= WR;
              bus_we_q   <= 1'b1;
              bus_dout_q <= lane_merge(bif.bus_din, req_lane_q, req_byte_q);
            end else begin
              state_q   <= ACK;
              bus_stb_q <= 1'b0;
              cpu_ack_q <= 1'b1;
              cpu_din_q <= req_ben_q ? lane_select(bif.bus_din, req_lane_q) : bif.bus_din;
            end
          end else if (tmo_evt_s) begin
            state_q   <= ACK;
            bus_stb_q <= 1'b0;
            cpu_ack_q <= 1'b1;
            cpu_din_q <= 32'h0000_0000;
          end
        end
        WR: begin
          if (ack_s || tmo_evt_s) begin
            state_q   <= ACK;
            bus_stb_q <= 1'b0;
            bus_we_q  <= 1'b0;
            cpu_ack_q <= 1'b1;
            cpu_din_q <= 32'h0000_0000;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_stb_q <= 1'b0;
          bus_we_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q  <= 1'b0;
      stk_ovfl_q <= 1'b0;
    end else begin
      bus_err_q  <= tmo_evt_s ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
      stk_ovfl_q <= stk_low_s ? 1'b1 : (err_clr ? 1'b0 : stk_ovfl_q);
    end
  end

  assign bif.cpu_ack  = cpu_ack_q;
  assign bif.cpu_din  = cpu_din_q;
  assign bif.bus_stb  = bus_stb_q;
  assign bif.bus_we   = bus_we_q;
  assign bif.bus_addr = bus_addr_q;
  assign bif.bus_dout = bus_dout_q;
  assign bus_err      = bus_err_q;
  assign stk_ovfl     = stk_ovfl_q;
endmodule

// File: tb/tb_cpu_bus_x.sv
// Randomised self-checking bench for cpu_bus_x against a memory-backed access model.
module tb_cpu_bus_x;
  localparam int ADDR_W    = 24;
  localparam int TMO_W     = 4;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] spx = 32'h0;
  logic [31:0] sp_limit = 32'h0;
  logic        stk_en = 1'b0;
  logic        bus_err, stk_ovfl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [21:0]];
  logic        exp_ovfl;

  cpu_bus_x_if #(.ADDR_W(ADDR_W)) bif ();

  cpu_bus_x #(.ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bif      (bif),
    .err_clr  (err_clr),
    .spx      (spx),
    .sp_limit (sp_limit),
    .stk_en   (stk_en),
    .bus_err  (bus_err),
    .stk_ovfl (stk_ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mem_touch(input logic [21:0] a);
    if (!mem.exists(a)) mem[a] = $urandom();
  endtask

  // One core access; the bench plays the bus slave, acking each phase after k strobe cycles.
  task automatic do_access(input logic we, input logic ben, input logic [23:0] addr,
                           input logic [31:0] wdata, input int k, input bit hang, input bit poke);
    logic [21:0] wa;
    logic [31:0] old_word, exp_din, exp_wr, seen_wr;
    int          l, exp_lat, cyc, stb_cnt, phase;
    bit          done, addr_ok, we_ok, wr_seen, exp_we;
    wa = addr[23:2];
    l  = int'(addr[1:0]);
    mem_touch(wa);
    old_word = mem[wa];
    exp_wr = ben ? ((old_word & ~(32'hFF << (8 * l))) | ({24'h0, wdata[7:0]} << (8 * l))) : wdata;
    if (hang) begin
      exp_din = 32'h0;
      exp_lat = TMO_LIMIT + 1;
    end else if (we) begin
      exp_din = 32'h0;
      exp_lat = ben ? 2 * k + 1 : k + 1;
    end else begin
      exp_din = ben ? ((old_word >> (8 * l)) & 32'hFF) : old_word;
      exp_lat = k + 1;
    end
    bif.cpu_stb = 1'b1; bif.cpu_we = we; bif.cpu_ben = ben;
    bif.cpu_addr = addr; bif.cpu_dout = wdata;
    @(negedge clk);
    // A second request while busy must be dropped.
    bif.cpu_stb  = poke;
    bif.cpu_we   = poke ? ~we : we;
    bif.cpu_addr = poke ? ~addr : addr;
    bif.cpu_dout = ~wdata;
    cyc = 1; stb_cnt = 0; phase = 0; done = 0;
    addr_ok = 1; we_ok = 1; wr_seen = 0; seen_wr = 32'h0;
    while (!done && cyc <= 100) begin
      bif.bus_ack = 1'b0;
      bif.bus_din = $urandom();
      if (cyc == 2) bif.cpu_stb = 1'b0;
      if (bif.cpu_ack === 1'b1) begin
        done = 1;
      end else begin
        if (bif.bus_stb === 1'b1) begin
          exp_we = we && (!ben || phase == 1);
          if (bif.bus_addr !== wa) addr_ok = 0;
          if (bif.bus_we !== exp_we) we_ok = 0;
          stb_cnt++;
          if (!hang && stb_cnt == k) begin
            bif.bus_ack = 1'b1;
            mem_touch(bif.bus_addr);
            if (bif.bus_we === 1'b1) begin
              seen_wr = bif.bus_dout;
              wr_seen = 1;
              mem[bif.bus_addr] = bif.bus_dout;
            end else begin
              bif.bus_din = mem[bif.bus_addr];
            end
            stb_cnt = 0;
            phase++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    bif.bus_ack = 1'b0;
    bif.cpu_stb = 1'b0;
    check("ack_latency", 32'(cyc), 32'(exp_lat));
    check("cpu_din", bif.cpu_din, exp_din);
    check("stb_dropped", {31'h0, bif.bus_stb}, 32'h0);
    check("bus_addr_stable", {31'h0, addr_ok}, 32'h1);
    check("bus_we_phase", {31'h0, we_ok}, 32'h1);
    check("write_issued", {31'h0, wr_seen}, {31'h0, we && !hang});
    if (wr_seen) check("bus_dout", seen_wr, exp_wr);
    check("bus_err", {31'h0, bus_err}, {31'h0, hang});
    @(negedge clk);
    check("ack_one_cycle", {31'h0, bif.cpu_ack}, 32'h0);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", {31'h0, bus_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit w, b, h, p;
    bif.cpu_stb = 1'b0; bif.cpu_we = 1'b0; bif.cpu_ben = 1'b0;
    bif.cpu_addr = '0; bif.cpu_dout = 32'h0; bif.bus_din = 32'h0; bif.bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cpu_ack", {31'h0, bif.cpu_ack}, 32'h0);
    check("rst_bus_stb", {31'h0, bif.bus_stb}, 32'h0);
    check("rst_bus_we", {31'h0, bif.bus_we}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_stk_ovfl", {31'h0, stk_ovfl}, 32'h0);
    check("rst_cpu_din", bif.cpu_din, 32'h0);
    check("rst_bus_dout", bif.bus_dout, 32'h0);
    check("rst_bus_addr", {10'h0, bif.bus_addr}, 32'h0);

    mem[22'h41] = 32'hDEADBEEF;
    do_access(1'b0, 1'b0, 24'h000104, 32'h0, 2, 1'b0, 1'b0);
    mem[22'h40] = 32'h11223344;
    do_access(1'b0, 1'b1, 24'h000102, 32'h0, 1, 1'b0, 1'b0);
    mem[22'h80] = 32'h11223344;
    do_access(1'b1, 1'b1, 24'h000203, 32'h000000AB, 2, 1'b0, 1'b0);
    check("byte_write_mem", mem[22'h80], 32'hAB223344);

    do_access(1'b0, 1'b0, 24'h000104, 32'h0, 1, 1'b1, 1'b0);
    pulse_clear();
    do_access(1'b1, 1'b1, 24'h000105, 32'h0000_0077, 1, 1'b1, 1'b0);
    check("aborted_rmw_mem", mem[22'h41], 32'hDEADBEEF);
    pulse_clear();
    do_access(1'b0, 1'b0, 24'h000104, 32'h0, TMO_LIMIT, 1'b0, 1'b0);

    bif.bus_ack = 1'b1;
    @(negedge clk);
    bif.bus_ack = 1'b0;
    check("idle_ack_no_cpu_ack", {31'h0, bif.cpu_ack}, 32'h0);
    check("idle_ack_no_stb", {31'h0, bif.bus_stb}, 32'h0);

    // Reset in the read phase of a byte store.
    bif.cpu_stb = 1'b1; bif.cpu_we = 1'b1; bif.cpu_ben = 1'b1;
    bif.cpu_addr = 24'h000301; bif.cpu_dout = 32'h5A;
    @(negedge clk);
    bif.cpu_stb = 1'b0;
    @(negedge clk);
    check("rd_phase_stb", {31'h0, bif.bus_stb}, 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_stb", {31'h0, bif.bus_stb}, 32'h0);
    check("mid_rst_ack", {31'h0, bif.cpu_ack}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_ack", {31'h0, bif.cpu_ack}, 32'h0);
    do_access(1'b1, 1'b0, 24'h000300, 32'hCAFEF00D, 3, 1'b0, 1'b0);
    check("post_rst_write", mem[22'hC0], 32'hCAFEF00D);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom());
      b = 1'($urandom());
      h = ($urandom_range(0, 7) == 0);
      p = 1'($urandom());
      do_access(w, b, 24'h000100 + 24'($urandom_range(0, 31)), $urandom(),
                int'($urandom_range(1, 5)), h, p);
      if (h) pulse_clear();
    end

    stk_en = 1'b1; sp_limit = 32'h8000; spx = 32'h8004;
    @(negedge clk);
    check("stk_above", {31'h0, stk_ovfl}, 32'h0);
    spx = 32'h7FFC;
    @(negedge clk);
    check("stk_below", {31'h0, stk_ovfl}, 32'h1);
    spx = 32'h9000;
    @(negedge clk);
    check("stk_sticky", {31'h0, stk_ovfl}, 32'h1);
    spx = 32'h7000; err_clr = 1'b1;
    @(negedge clk);
    check("stk_set_beats_clr", {31'h0, stk_ovfl}, 32'h1);
    spx = 32'h9000;
    @(negedge clk);
    err_clr = 1'b0;
    check("stk_cleared", {31'h0, stk_ovfl}, 32'h0);

    exp_ovfl = 1'b0;
    for (int i = 0; i < 24; i++) begin
      stk_en  = 1'($urandom());
      spx     = 32'h8000 + 32'($urandom_range(0, 16)) - 32'd8;
      err_clr = ($urandom_range(0, 3) == 0);
      if (stk_en && spx < sp_limit) exp_ovfl = 1'b1;
      else if (err_clr) exp_ovfl = 1'b0;
      @(negedge clk);
      check("stk_rand", {31'h0, stk_ovfl}, {31'h0, exp_ovfl});
    end
    err_clr = 1'b0;
    stk_en  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
